// File: rtl/spi_ram_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_ram_ctrl_if
// Description : CPU-side request/response bundle for spi_ram_ctrl. The
//               master modport is the requester, the slave modport is the
//               SPI SRAM controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_ram_ctrl_if;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic        start_read;
    logic        start_write;
    logic [31:0] rdata;
    logic        busy;
    logic        done;

    modport master (
        output addr, wdata, start_read, start_write,
        input  rdata, busy, done
    );

    modport slave (
        input  addr, wdata, start_read, start_write,
        output rdata, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/spi_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spi_ram_ctrl
// Description : Single-transaction SPI mode-0 master for an external SPI
//               SRAM. Sends {opcode, 24-bit address, 4 data bytes} MSB
//               first at clk/2 and returns read data little-endian.
//               Optional macro SPI_RAM_FAST_READ_EN: reads use opcode 0x0B
//               with 8 dummy bits between address and data.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_ram_ctrl #(
    parameter logic [7:0] CMD_READ  = 8'h03,
    parameter logic [7:0] CMD_WRITE = 8'h02
) (
    input  wire logic       clk,
    input  wire logic       rst,
    spi_ram_ctrl_if.slave   bus,
    output logic            spi_select,
    output logic            spi_clk,
    output logic            spi_mosi,
    input  wire logic       spi_miso
);

`ifdef SPI_RAM_FAST_READ_EN
    localparam int         c_sr_w     = 72;
    localparam logic [6:0] c_rd_last  = 7'd71;
`else
    localparam int         c_sr_w     = 64;
    localparam logic [6:0] c_rd_last  = 7'd63;
`endif
    localparam logic [6:0] c_wr_last  = 7'd63;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    // Wire byte order is the reverse of the CPU word byte order.
    function automatic logic [31:0] f_swap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    state_t              r_state;
    logic                r_select;
    logic                r_sclk;
    logic                r_mosi;
    logic                r_busy;
    logic                r_done;
    logic                r_is_read;
    logic [31:0]         r_rdata;
    logic [31:0]         r_rx;
    logic [6:0]          r_cnt;
    // Bits still to be sent after the one currently on spi_mosi.
    logic [c_sr_w-2:0]   r_sr;

    logic                w_start;
    logic [c_sr_w-1:0]   w_rd_frame;
    logic [c_sr_w-1:0]   w_wr_frame;
    logic [c_sr_w-1:0]   w_frame;

    assign w_start = bus.start_read | bus.start_write;

    // Complete outgoing frames, left-aligned so the opcode MSB goes first.
`ifdef SPI_RAM_FAST_READ_EN
    assign w_rd_frame = {8'h0B, bus.addr, 8'h00, 32'h0};
    assign w_wr_frame = {CMD_WRITE, bus.addr, f_swap(bus.wdata), 8'h00};
`else
    assign w_rd_frame = {CMD_READ, bus.addr, 32'h0};
    assign w_wr_frame = {CMD_WRITE, bus.addr, f_swap(bus.wdata)};
`endif

    // Read wins when both starts are raised together.
    assign w_frame = bus.start_read ? w_rd_frame : w_wr_frame;

    // Transaction FSM: accept, shift the frame out at clk/2, then close.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_select  <= 1'b1;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_is_read <= 1'b0;
            r_rdata   <= 32'h0;
            r_rx      <= 32'h0;
            r_cnt     <= 7'd0;
            r_sr      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // busy is still high for the cycle after done, yet a
                    // start on that edge is accepted (back-to-back timing).
                    if (w_start) begin
                        r_is_read <= bus.start_read;
                        r_mosi    <= w_frame[c_sr_w-1];
                        r_sr      <= w_frame[c_sr_w-2:0];
                        r_cnt     <= bus.start_read ? c_rd_last : c_wr_last;
                        r_select  <= 1'b0;
                        r_sclk    <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= S_SHIFT;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (!r_sclk) begin
                        r_sclk <= 1'b1;
                    end else begin
                        // Falling SPI edge: sample MISO, present next bit.
                        r_sclk <= 1'b0;
                        r_mosi <= r_sr[c_sr_w-2];
                        r_sr   <= {r_sr[c_sr_w-3:0], 1'b0};
                        if (r_is_read) begin
                            r_rx <= {r_rx[30:0], spi_miso};
                        end
                        if (r_cnt == 7'd0) begin
                            r_state <= S_FINISH;
                        end else begin
                            r_cnt <= r_cnt - 7'd1;
                        end
                    end
                end
                S_FINISH: begin
                    // Last 32 received bits are the data phase.
                    r_select <= 1'b1;
                    r_mosi   <= 1'b0;
                    r_done   <= 1'b1;
                    if (r_is_read) begin
                        r_rdata <= f_swap(r_rx);
                    end
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign spi_select = r_select;
    assign spi_clk    = r_sclk;
    assign spi_mosi   = r_mosi;
    assign bus.rdata  = r_rdata;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_spi_ram_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_spi_ram_ctrl
// Description : Directed self-checking bench for spi_ram_ctrl with a small
//               behavioural SPI SRAM model (default build, opcode 0x03).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_ram_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic spi_select;
    logic spi_clk;
    logic spi_mosi;
    logic spi_miso = 1'b0;

    spi_ram_ctrl_if bus ();

    spi_ram_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .spi_select (spi_select),
        .spi_clk    (spi_clk),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;

    // Clock
    always #5 clk = ~clk;

    // Edge counter: value at a negedge equals the index of the last posedge.
    always @(posedge clk) cyc <= cyc + 1;

    // Count done pulses over the whole run.
    always @(posedge clk) if (bus.done === 1'b1) done_cnt <= done_cnt + 1;

    // ---------------- SPI SRAM model ----------------
    logic [7:0]  mem [0:1023];
    int          bitn = 0;
    int          rises = 0;
    int          mwrites = 0;
    logic [63:0] msh = 64'h0;
    logic [7:0]  mop = 8'h0;
    logic [23:0] maddr = 24'h0;
    logic [9:0]  midx;
    logic [7:0]  mbyte;
    int          d;

    // New transaction begins on a falling select.
    always @(negedge spi_select) begin
        bitn  = 0;
        rises = 0;
        mop   = 8'h0;
    end

    // SRAM samples MOSI on rising SPI clock and updates MISO for this bit.
    always @(posedge spi_clk) begin
        if (!spi_select) begin
            msh = {msh[62:0], spi_mosi};
            bitn++;
            rises++;
            if (bitn == 8)  mop   = msh[7:0];
            if (bitn == 32) maddr = msh[23:0];
            if (mop == 8'h02 && bitn > 32 && (bitn % 8) == 0) begin
                midx = maddr[9:0] + 10'((bitn - 40) / 8);
                mem[midx] = msh[7:0];
                mwrites++;
            end
            if (mop == 8'h03 && bitn > 32) begin
                d     = bitn - 33;
                midx  = maddr[9:0] + 10'(d / 8);
                mbyte = mem[midx];
                spi_miso = mbyte[7 - (d % 8)];
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [23:0] a,
                         input logic [31:0] w, output int e0);
        @(negedge clk);
        bus.start_read  = rd;
        bus.start_write = wr;
        bus.addr        = a;
        bus.wdata       = w;
        @(negedge clk);
        bus.start_read  = 1'b0;
        bus.start_write = 1'b0;
        e0 = cyc;
    endtask

    task automatic wait_done(input int e0, input string tag);
        int n = 0;
        while (bus.done !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, 64'(bus.done), 64'h1);
        chk({tag, "_done_time"}, 64'(cyc - e0), 64'd129);
    endtask

    int e0, e1, dc0, w0;

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus.start_read  = 1'b0;
        bus.start_write = 1'b0;
        bus.addr        = 24'h0;
        bus.wdata       = 32'h0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[10'h010] = 8'h5A; mem[10'h011] = 8'h6B;
        mem[10'h012] = 8'h7C; mem[10'h013] = 8'h8D;
        mem[10'h200] = 8'h11; mem[10'h201] = 8'h22;
        mem[10'h202] = 8'h33; mem[10'h203] = 8'h44;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // 1. Reset state held through 10 idle cycles
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_ctrl", 64'({spi_select, spi_clk, spi_mosi, bus.busy, bus.done}), 64'b10000);
            chk("idle_rdata", 64'(bus.rdata), 64'h0);
        end

        // 2. Write 0xDDCCBBAA to 0x000100
        issue(1'b0, 1'b1, 24'h000100, 32'hDDCCBBAA, e0);
        chk("wr_accept", 64'({spi_select, bus.busy}), 64'b01);
        wait_done(e0, "wr");
        chk("wr_rises", 64'(rises), 64'd64);
        chk("wr_stream", msh, 64'h02000100AABBCCDD);
        chk("wr_done_sel_busy", 64'({spi_select, bus.busy, spi_mosi}), 64'b110);
        @(negedge clk);
        chk("wr_busy_fall", 64'({bus.busy, bus.done}), 64'b00);
        chk("wr_mem", 64'({mem[10'h100], mem[10'h101], mem[10'h102], mem[10'h103]}), 64'hAABBCCDD);
        chk("wr_count", 64'(mwrites), 64'd4);

        // 3. Read back 0x000100
        issue(1'b1, 1'b0, 24'h000100, 32'h0, e0);
        wait_done(e0, "rd");
        chk("rd_rdata", 64'(bus.rdata), 64'hDDCCBBAA);
        chk("rd_cmd_addr", 64'(msh[63:32]), 64'h03000100);
        chk("rd_rises", 64'(rises), 64'd64);
        @(negedge clk);
        chk("rd_busy_fall", 64'(bus.busy), 64'h0);

        // 4. Simultaneous read and write: read wins
        w0  = mwrites;
        dc0 = done_cnt;
        issue(1'b1, 1'b1, 24'h000010, 32'hCAFEF00D, e0);
        wait_done(e0, "both");
        chk("both_opcode", 64'(mop), 64'h03);
        chk("both_rdata", 64'(bus.rdata), 64'h8D7C6B5A);
        repeat (5) @(negedge clk);
        chk("both_done_cnt", 64'(done_cnt - dc0), 64'd1);
        chk("both_no_write", 64'(mwrites - w0), 64'd0);

        // 5. Start while busy ignored; back-to-back re-issue accepted
        dc0 = done_cnt;
        issue(1'b1, 1'b0, 24'h000100, 32'h0, e0);
        while (cyc < e0 + 39) @(negedge clk);
        bus.start_read = 1'b1;
        bus.addr       = 24'h000010;
        @(negedge clk);
        bus.start_read = 1'b0;
        chk("b2b_ignored_busy", 64'({spi_select, bus.busy}), 64'b01);
        wait_done(e0, "b2b_first");
        chk("b2b_first_rdata", 64'(bus.rdata), 64'hDDCCBBAA);
        chk("b2b_gap_sel_high", 64'(spi_select), 64'h1);
        bus.start_read = 1'b1;
        bus.addr       = 24'h000200;
        @(negedge clk);
        bus.start_read = 1'b0;
        e1 = cyc;
        chk("b2b_accept_edge", 64'(e1 - e0), 64'd130);
        chk("b2b_sel_low_again", 64'({spi_select, bus.busy}), 64'b01);
        wait_done(e1, "b2b_second");
        chk("b2b_second_rdata", 64'(bus.rdata), 64'h44332211);
        repeat (5) @(negedge clk);
        chk("b2b_done_cnt", 64'(done_cnt - dc0), 64'd2);

        // 6. Reset in the middle of a write
        dc0 = done_cnt;
        w0  = mwrites;
        issue(1'b0, 1'b1, 24'h000300, 32'h12345678, e0);
        while (cyc < e0 + 59) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_outputs", 64'({spi_select, spi_clk, spi_mosi, bus.busy, bus.done}), 64'b10000);
        chk("rst_rdata", 64'(bus.rdata), 64'h0);
        rst = 1'b0;
        repeat (150) @(negedge clk);
        chk("rst_no_done", 64'(done_cnt - dc0), 64'd0);
        chk("rst_no_write", 64'(mwrites - w0), 64'd0);
        chk("rst_mem_untouched", 64'(mem[10'h300]), 64'h00);
        issue(1'b1, 1'b0, 24'h000200, 32'h0, e0);
        wait_done(e0, "post_rst_rd");
        chk("post_rst_rdata", 64'(bus.rdata), 64'h44332211);
        @(negedge clk);
        chk("post_rst_busy_fall", 64'(bus.busy), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
